// File: rtl/eth_widen_pkg.sv
// Shared helpers for the narrow-to-wide Ethernet RX packing FIFO.
package eth_widen_pkg;

  localparam int unsigned MAX_RATIO = 32;

  function automatic int unsigned wide_w(input int unsigned narrow_w, input int unsigned ratio);
    return narrow_w * ratio;
  endfunction

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Lanes 0..lane set; callers cast down to their own lane count.
  function automatic logic [MAX_RATIO-1:0] keep_mask(input int unsigned lane);
    logic [MAX_RATIO-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_RATIO; i++) begin
      m[i] = (i <= lane);
    end
    return m;
  endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with an enable-gated output register.
module eth_sdp_ram
  import eth_widen_pkg::*;
#(
  parameter int unsigned WIDTH = 69,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = addr_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Output register holds its word until the next read enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_o <= '0;
    else if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/eth_widen_fifo.sv
// Packs RATIO narrow beats into one wide word with keep/last and buffers DEPTH words.
module eth_widen_fifo
  import eth_widen_pkg::*;
#(
  parameter int unsigned NARROW_W = 16,
  parameter int unsigned RATIO    = 4,
  parameter int unsigned DEPTH    = 512,
  localparam int unsigned WIDE_W  = wide_w(NARROW_W, RATIO),
  localparam int unsigned AW      = addr_w(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic [NARROW_W-1:0] in_data_i,
  input  logic                in_valid_i,
  input  logic                in_last_i,
  output logic                in_ready_o,
  output logic [WIDE_W-1:0]   out_data_o,
  output logic [RATIO-1:0]    out_keep_o,
  output logic                out_last_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [AW:0]         fill_o
);

  localparam int unsigned LW = $clog2(RATIO);
  localparam int unsigned MW = WIDE_W + RATIO + 1;

  logic [LW-1:0]       lane_q;
  logic [NARROW_W-1:0] pack_q [RATIO-1];
  logic [AW:0]         wr_ptr_q;
  logic [AW:0]         rd_ptr_q;
  logic                out_valid_q;
  logic                full;
  logic                empty;
  logic                accept;
  logic                commit;
  logic                rd_en;
  logic [WIDE_W-1:0]   commit_data;
  logic [RATIO-1:0]    commit_keep;
  logic [MW-1:0]       ram_wdata;
  logic [MW-1:0]       ram_rdata;

  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  // Ready ignores lane_q: a beat that would only fill the pack register is still refused when full.
  assign in_ready_o = !full && !flush_i;
  assign accept = in_valid_i && in_ready_o;
  assign commit = accept && ((lane_q == LW'(RATIO - 1)) || in_last_i);
  assign rd_en  = !empty && (!out_valid_q || out_ready_i) && !flush_i;

  always_comb begin
    commit_data = '0;
    for (int i = 0; i < RATIO - 1; i++) begin
      if (LW'(i) < lane_q) commit_data[i*NARROW_W +: NARROW_W] = pack_q[i];
    end
    for (int i = 0; i < RATIO; i++) begin
      if (LW'(i) == lane_q) commit_data[i*NARROW_W +: NARROW_W] = in_data_i;
    end
  end

  assign commit_keep = RATIO'(keep_mask(32'(lane_q)));
  assign ram_wdata   = {in_last_i, commit_keep, commit_data};

  // Pack stage: lane counter, pointers and output-valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      lane_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept)      lane_q   <= commit ? '0 : lane_q + LW'(1);
      if (commit)      wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en)       rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (rd_en)            out_valid_q <= 1'b1;
      else if (out_ready_i) out_valid_q <= 1'b0;
    end
  end

  // Pack lanes carry no reset; lane_q alone decides which of them are live.
  always_ff @(posedge clk_i) begin
    if (accept && !commit) begin
      for (int i = 0; i < RATIO - 1; i++) begin
        if (lane_q == LW'(i)) pack_q[i] <= in_data_i;
      end
    end
  end

  // Storage and output stage.
  eth_sdp_ram #(
    .WIDTH (MW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (commit),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (ram_wdata),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign {out_last_o, out_keep_o, out_data_o} = ram_rdata;
  assign out_valid_o = out_valid_q;
  assign fill_o      = wr_ptr_q - rd_ptr_q;

endmodule

// File: doc/eth_widen_fifo.md
# eth_widen_fifo

Parametrised single-clock narrow-to-wide packing FIFO for the Ethernet RX datapath: it accepts NARROW_W-bit beats over a valid/ready stream, packs RATIO beats into one wide word with per-lane keep and a frame-last flag, buffers DEPTH wide words in a simple dual-port RAM, and presents them on a wide valid/ready stream. It is the successor of the fixed 16→64 widening buffer and adds generic widths and depth, backpressure, partial-word handling at frame end, occupancy reporting and flush.

## Interface
- NARROW_W, 16, input beat width in bits (multiple of 8)
- RATIO, 4, narrow beats per wide word (power of 2, ≥2); WIDE_W = NARROW_W*RATIO
- DEPTH, 512, wide words of storage (power of 2, ≥2); AW = $clog2(DEPTH)
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low
- flush_i  in  1  synchronous clear of all content, pack state and output stage
- in_data_i  in  NARROW_W  input beat
- in_valid_i  in  1  input beat valid
- in_last_i  in  1  beat is last of frame
- in_ready_o  out  1  input beat accepted when valid&ready
- out_data_o  out  WIDE_W  wide word; lane 0 = bits [NARROW_W-1:0] = first beat
- out_keep_o  out  RATIO  lane-valid mask, contiguous from lane 0
- out_last_o  out  1  word closes a frame
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  output consumer ready
- fill_o  out  AW+1  wide words in RAM (excludes output stage and pack register)

## Operation
- Pack: lane counter lane_q (0..RATIO-1) plus pack register of RATIO-1 lanes. Accepted beat with lane_q<RATIO-1 and !in_last_i: store in lane lane_q, lane_q++.
- Commit: accepted beat with lane_q==RATIO-1 or in_last_i: word {beat in lane lane_q, pack lanes below} written to RAM at wr_ptr at that edge; keep = lanes 0..lane_q set, others 0; last = in_last_i; unused lanes written 0; lane_q←0; wr_ptr++.
- Pointers wr_ptr/rd_ptr are AW+1 bits (wrap bit); full = MSBs differ and low AW bits equal; empty = equal; fill_o = wr_ptr−rd_ptr.
- in_ready_o = !full && !flush_i (conservative: low when storage full, regardless of lane_q).
- Read: rd_en = !empty && (!out_valid_o || out_ready_i) && !flush_i. RAM output register loads only on rd_en and holds otherwise; rd_ptr++ on rd_en; out_valid_o set on rd_en, cleared on handshake without rd_en.
- Same-address read/write impossible: reads need !empty, writes need !full.
- flush_i: pointers, lane_q, out_valid_o cleared next edge; beats presented that cycle not accepted; partial pack data discarded.
- Output register data/keep/last are don't-care while out_valid_o=0.

## Timing
- Reset: in_ready_o=1, out_valid_o=0, out_keep_o=0, out_last_o=0, out_data_o=0, fill_o=0, lane_q=0.
- Latency: committing beat at edge t → fill_o=1 after t → out_valid_o=1 after edge t+1 (2 cycles).
- Throughput: one wide word per cycle out with out_ready_i held high; one narrow beat per cycle in while !full.
- Total capacity: DEPTH words in RAM + 1 in output stage + partial pack.
- Simultaneous commit and read: fill_o unchanged.
- Reset assertion mid-frame: all state cleared asynchronously; no partial word survives.

## Structure
- Package eth_widen_pkg: keep-mask function lane_index→RATIO-bit mask, WIDE_W/AW derivation helpers.
- Sub-module eth_sdp_ram: simple dual-port, one write port, one read port with enable-gated output register, DEPTH×(WIDE_W+RATIO+1), no reset on array; output register reset to 0.
- Top holds pack logic, pointers, output-valid control.

## Test plan
- Defaults, beats 0x0001..0x0008 then last on 8th → two words 0x0004_0003_0002_0001 keep 0xF last 0, 0x0008_0007_0006_0005 keep 0xF last 1; first out_valid 2 cycles after 4th beat.
- 3-beat frame 0xAAAA,0xBBBB,0xCCCC with last → word 0x0000_CCCC_BBBB_AAAA keep 0x7 last 1; 1-beat frame → keep 0x1.
- out_ready_i=0, stream 4*DEPTH+4 beats → in_ready_o drops when fill_o=DEPTH; release → all DEPTH+1 words in order, no loss, no duplicate.
- Continuous in/out with out_ready_i random 50% → scoreboard match, pointer wrap exercised ≥3 times.
- flush_i with 2 beats packed and 5 words stored → next cycle fill_o=0, out_valid_o=0; next frame starts in lane 0.
- rst_ni pulsed low mid-frame → all outputs at reset values immediately; subsequent frame correct.
